load_unit: RTL and testbench
============================

# load_unit

Memory-stage load unit of the core, sitting between the LSU issue path and the data-memory port. It accepts one load request at a time, issues word-aligned read requests to memory, and right-aligns the returned byte lanes by the address offset. It then sign- or zero-extends the result to 32 bits and hands it to writeback through a valid/ready handshake. It is the read-side counterpart of the store path's left-shift lane placement.

## Interface
- MISALIGNED_LOAD_EN (macro, see Configuration)
- clk  input  1  core clock; all state updates on its rising edge
- reset_n  input  1  synchronous, active-low reset
- req_valid_i  input  1  load request valid
- req_ready_o  output  1  unit can accept a request
- req_addr_i  input  32  byte address
- req_size_i  input  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- req_unsigned_i  input  1  1 = zero-extend, 0 = sign-extend
- req_rd_i  input  5  destination register tag, returned unchanged
- flush_i  input  1  abort the current load
- mem_req_valid_o  output  1  memory read request valid
- mem_req_ready_i  input  1  memory accepts the request
- mem_addr_o  output  32  word-aligned read address, bits [1:0] always 00
- mem_rsp_valid_i  input  1  read data valid (single-cycle pulse)
- mem_rsp_data_i  input  32  read data, little-endian
- wb_valid_o  output  1  result valid
- wb_ready_i  input  1  writeback accepts the result
- wb_data_o  output  32  aligned and extended load data
- wb_rd_o  output  5  captured req_rd_i
- exc_misaligned_o  output  1  misaligned fault, qualified by wb_valid_o

## Operation
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP, DRAIN.
- IDLE
  - req_ready_o = 1; no other state asserts it.
  - A handshake (req_valid_i & req_ready_o) captures addr, size, unsigned and rd, then moves to REQ0.
- REQ0
  - mem_req_valid_o = 1, mem_addr_o = {addr[31:2], 2'b00}.
  - On mem_req_ready_i, go to WAIT0.
- WAIT0
  - On mem_rsp_valid_i, store the word in lo.
  - Go to REQ1 if the access spans two words: half with off = 3, or word with off ≠ 0. Otherwise go to RESP.
- REQ1
  - mem_addr_o = {addr[31:2], 2'b00} + 4, wrapping modulo 2^32 (0xFFFFFFFC → 0x00000000).
  - On mem_req_ready_i, go to WAIT1.
- WAIT1: on mem_rsp_valid_i, store the word in hi and go to RESP.
- RESP
  - Form {hi, lo}; hi = 0 for single-word loads.
  - Shift right by 8·off and take the low 8, 16 or 32 bits per size.
  - Extend: bit 7 / bit 15 for signed loads, zero for unsigned loads.
  - Hold wb_valid_o = 1 with stable data until wb_ready_i, then go to IDLE.
- mem_rsp_valid_i outside WAIT0, WAIT1 and DRAIN is ignored.
- flush_i, with priority over all other events in the same cycle:
  - IDLE / REQ0 / REQ1 / RESP → IDLE. wb_valid_o drops next cycle.
  - WAIT0 / WAIT1 → DRAIN. DRAIN discards one mem_rsp_valid_i, then goes to IDLE.
  - A flush in the same cycle as a request handshake drops that request.
- A flush in REQ0/REQ1 in the same cycle as mem_req_ready_i also goes to DRAIN, because the request was accepted.

## Timing
- Reset values: req_ready_o = 1 (state IDLE). mem_req_valid_o, wb_valid_o and exc_misaligned_o = 0. mem_addr_o, wb_data_o and wb_rd_o = 0.
- Outputs are registered or decoded from state only. There is no combinational path from mem_rsp_data_i to wb_data_o.
- Aligned load with zero memory wait states:
  - Handshake at cycle 0, REQ0 at cycle 1.
  - Response no earlier than cycle 2.
  - wb_valid_o at cycle 3.
- Split load: two extra cycles minimum.
- Throughput: one load per (latency + 1) cycles. There is no back-to-back acceptance.
- Reset mid-operation returns to IDLE on the next edge. Any in-flight memory response is then ignored.

## Configuration
- MISALIGNED_LOAD_EN defined: spanning loads are split into two reads as described above. exc_misaligned_o is tied to 0.
- MISALIGNED_LOAD_EN undefined:
  - Any half with off[0] = 1, or word with off ≠ 0, goes IDLE → REQ0-free → RESP with no memory access.
  - It presents wb_valid_o = 1, exc_misaligned_o = 1, wb_data_o = 0.
  - REQ1 and WAIT1 are not built.

## Structure
- Shared package lsu_pkg:
  - size encodings (SIZE_B, SIZE_H, SIZE_W)
  - state enum
  - spans_two_words helper function
- Sub-module load_extract: combinational; inputs 64-bit {hi, lo}, off, size, unsigned; output 32-bit extended result. load_unit instantiates it in RESP.

## Test plan
- Signed byte: addr 0x1003, mem word 0x80FF_1234 → wb_data_o = 0xFFFF_FF80, one memory request at address 0x1000.
- Unsigned half: addr 0x2002, word 0xBEEF_0000 → 0x0000_BEEF, wb_rd_o matches req_rd_i.
- Split word (macro on): addr 0x3001, words 0x4433_2211 then 0x8877_6655 → requests to 0x3000 then 0x3004; result 0x5544_3322.
- Misaligned word (macro off): addr 0x3002 → no mem_req_valid_o; wb_valid_o and exc_misaligned_o both high; data 0.
- Wrap: split word at 0xFFFF_FFFE → second address 0x0000_0000.
- Flush in WAIT0, followed by the response, then a new load → the discarded response produces no wb_valid_o, and the new load completes with correct data. Also hold wb_ready_i = 0 for 5 cycles and check that wb_data_o stays stable.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared load/store size encodings, load FSM states and lane-span helpers.
package lsu_pkg;
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  typedef enum logic [2:0] {S_IDLE, S_REQ0, S_WAIT0, S_REQ1, S_WAIT1, S_RESP, S_DRAIN} state_e;
  // Size 2'b11 is reserved and behaves as a word everywhere.
  function automatic logic spans_two_words(input logic [1:0] size, input logic [1:0] off);
    return (size == SIZE_H) ? (off == 2'd3) : (size != SIZE_B) && (off != 2'd0);
  endfunction
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    return (size == SIZE_H) ? off[0] : (size != SIZE_B) && (off != 2'd0);
  endfunction
endpackage

// File: rtl/load_extract.sv
// load_extract: right-aligns the addressed lanes of {hi, lo} and sign/zero-extends to 32 bits.
module load_extract
  import lsu_pkg::*;
(
  input  logic [63:0] data_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);
  logic [31:0] sh;
  assign sh = 32'(data_i >> {off_i, 3'b000});
  always_comb data_o = (size_i == SIZE_B) ? {{24{~unsigned_i & sh[7]}}, sh[7:0]} :
                       (size_i == SIZE_H) ? {{16{~unsigned_i & sh[15]}}, sh[15:0]} : sh;
endmodule

// File: rtl/load_unit.sv
// load_unit: memory-stage load unit issuing word-aligned reads and returning aligned, extended data.
// MISALIGNED_LOAD_EN splits word-spanning loads into two reads; otherwise they raise exc_misaligned_o.
module load_unit
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [4:0]  req_rd_i,
  input  logic        flush_i,
  output logic        mem_req_valid_o,
  input  logic        mem_req_ready_i,
  output logic [31:0] mem_addr_o,
  input  logic        mem_rsp_valid_i,
  input  logic [31:0] mem_rsp_data_i,
  output logic        wb_valid_o,
  input  logic        wb_ready_i,
  output logic [31:0] wb_data_o,
  output logic [4:0]  wb_rd_o,
  output logic        exc_misaligned_o
);
  state_e      state_q;
  logic [31:0] addr_q, lo_q, hi, base, ext;
  logic [1:0]  size_q;
  logic        uns_q, exc;
  logic [4:0]  rd_q;
`ifdef MISALIGNED_LOAD_EN
  logic [31:0] hi_q;
  assign hi  = hi_q;
  assign exc = 1'b0;
`else
  logic exc_q, mis;
  assign hi  = '0;
  assign exc = exc_q;
  assign mis = misaligned(req_size_i, req_addr_i[1:0]);
`endif
  assign base             = {addr_q[31:2], 2'b00};
  assign req_ready_o      = state_q == S_IDLE;
  assign mem_req_valid_o  = state_q == S_REQ0 || state_q == S_REQ1;
  assign mem_addr_o       = (state_q == S_REQ1) ? base + 32'd4 : (state_q == S_REQ0) ? base : '0;
  assign wb_valid_o       = state_q == S_RESP;
  assign wb_data_o        = (wb_valid_o && !exc) ? ext : '0;
  assign wb_rd_o          = rd_q;
  assign exc_misaligned_o = wb_valid_o & exc;
  load_extract u_extract (
    .data_i     ({hi, lo_q}),
    .off_i      (addr_q[1:0]),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .data_o     (ext)
  );
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      size_q  <= SIZE_B;
      uns_q   <= 1'b0;
      rd_q    <= '0;
      lo_q    <= '0;
`ifdef MISALIGNED_LOAD_EN
      hi_q    <= '0;
`else
      exc_q   <= 1'b0;
`endif
    end else if (flush_i && state_q != S_DRAIN) begin
      // An accepted memory request still owes a response that must be swallowed.
      state_q <= (state_q == S_WAIT0 || state_q == S_WAIT1 ||
                  ((state_q == S_REQ0 || state_q == S_REQ1) && mem_req_ready_i)) ? S_DRAIN : S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (req_valid_i) begin
          addr_q <= req_addr_i;
          size_q <= req_size_i;
          uns_q  <= req_unsigned_i;
          rd_q   <= req_rd_i;
          lo_q   <= '0;
`ifdef MISALIGNED_LOAD_EN
          hi_q    <= '0;
          state_q <= S_REQ0;
`else
          exc_q   <= mis;
          state_q <= mis ? S_RESP : S_REQ0;
`endif
        end
        S_REQ0: if (mem_req_ready_i) state_q <= S_WAIT0;
        S_WAIT0: if (mem_rsp_valid_i) begin
          lo_q <= mem_rsp_data_i;
`ifdef MISALIGNED_LOAD_EN
          state_q <= spans_two_words(size_q, addr_q[1:0]) ? S_REQ1 : S_RESP;
`else
          state_q <= S_RESP;
`endif
        end
`ifdef MISALIGNED_LOAD_EN
        S_REQ1: if (mem_req_ready_i) state_q <= S_WAIT1;
        S_WAIT1: if (mem_rsp_valid_i) begin
          hi_q    <= mem_rsp_data_i;
          state_q <= S_RESP;
        end
`endif
        S_RESP: if (wb_ready_i) state_q <= S_IDLE;
        S_DRAIN: if (mem_rsp_valid_i) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_unit.sv
// tb_load_unit: table-driven load vectors with a writeback scoreboard and a memory model.
module tb_load_unit;
  logic        clk = 0, reset_n = 0;
  logic        req_valid_i = 0, req_ready_o, req_unsigned_i = 0, flush_i = 0;
  logic [31:0] req_addr_i = 0, mem_addr_o, mem_rsp_data_i = 0, wb_data_o;
  logic [1:0]  req_size_i = 0;
  logic [4:0]  req_rd_i = 0, wb_rd_o;
  logic        mem_req_valid_o, mem_req_ready_i = 0, mem_rsp_valid_i = 0;
  logic        wb_valid_o, wb_ready_i = 0, exc_misaligned_o;

  load_unit dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i), .req_rd_i(req_rd_i),
    .flush_i(flush_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i), .mem_addr_o(mem_addr_o),
    .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_data_i(mem_rsp_data_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_data_o(wb_data_o),
    .wb_rd_o(wb_rd_o), .exc_misaligned_o(exc_misaligned_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [4:0]  rd;
    logic [31:0] w0, w1, exp;
    logic        exc;
    int          nreq, lat, hold;
  } vec_t;
  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        exc;
  } wb_t;

  int checks = 0, errors = 0;
  int nreq = 0, pend_cnt = 0, rsp_delay = 0, hold_cnt = 0;
  logic mem_stall = 0;
  logic [31:0] pend_data;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] exp_addr_q [$];
  wb_t wb_q [$];
  vec_t vecs [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] a, input logic [1:0] s, input logic u, input logic [4:0] rd,
                              input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] exp,
                              input logic exc, input int n, input int lat, input int hold);
    vec_t v;
    v.addr = a; v.size = s; v.uns = u; v.rd = rd; v.w0 = w0; v.w1 = w1; v.exp = exp;
    v.exc = exc; v.nreq = n; v.lat = lat; v.hold = hold;
    return v;
  endfunction

  // Memory model: ready whenever a request is seen, response rsp_delay cycles after acceptance.
  always @(negedge clk) begin
    mem_rsp_valid_i = 0;
    if (pend_cnt == 1) begin
      mem_rsp_valid_i = 1;
      mem_rsp_data_i  = pend_data;
    end
    if (pend_cnt > 0) pend_cnt--;
    mem_req_ready_i = 0;
    if (reset_n && mem_req_valid_o && !mem_stall) begin
      mem_req_ready_i = 1;
      nreq++;
      if (exp_addr_q.size() == 0) chk("mem_unexpected_req", mem_addr_o, 32'hxxxx_xxxx);
      else chk("mem_addr", mem_addr_o, exp_addr_q.pop_front());
      pend_data = mem.exists(mem_addr_o) ? mem[mem_addr_o] : 32'h0;
      pend_cnt  = 1 + rsp_delay;
    end
  end

  // Writeback scoreboard: every cycle wb_valid_o is high the front entry is compared.
  always @(negedge clk) begin
    wb_ready_i = 0;
    if (reset_n && wb_valid_o) begin
      if (wb_q.size() == 0) begin
        chk("wb_unexpected", {31'b0, wb_valid_o}, 32'h0);
        wb_ready_i = 1;
      end else begin
        chk("wb_data", wb_data_o, wb_q[0].data);
        chk("wb_rd", {27'b0, wb_rd_o}, {27'b0, wb_q[0].rd});
        chk("wb_exc", {31'b0, exc_misaligned_o}, {31'b0, wb_q[0].exc});
        if (hold_cnt == 0) begin
          wb_ready_i = 1;
          void'(wb_q.pop_front());
        end else hold_cnt--;
      end
    end
  end

  task automatic issue(input vec_t v);
    logic [31:0] b;
    int n;
    b = {v.addr[31:2], 2'b00};
    mem[b] = v.w0;
    mem[b + 32'd4] = v.w1;
    if (v.nreq > 0) exp_addr_q.push_back(b);
    if (v.nreq > 1) exp_addr_q.push_back(b + 32'd4);
    wb_q.push_back('{data: v.exp, rd: v.rd, exc: v.exc});
    hold_cnt = v.hold;
    nreq = 0;
    n = 0;
    @(negedge clk);
    while (!req_ready_o && n < 20) begin @(negedge clk); n++; end
    req_valid_i = 1; req_addr_i = v.addr; req_size_i = v.size;
    req_unsigned_i = v.uns; req_rd_i = v.rd;
    n = 0;
    do begin
      @(negedge clk);
      req_valid_i = 0;
      n++;
    end while (!wb_valid_o && n < 20);
    chk("latency", n, v.lat);
    n = 0;
    while ((wb_q.size() != 0 || !req_ready_o) && n < 30) begin @(negedge clk); n++; end
    chk("complete", {31'b0, wb_q.size() == 0 && req_ready_o}, 32'h1);
    chk("mem_req_count", nreq, v.nreq);
  endtask

  initial begin
    vecs.push_back(mk(32'h0000_1003, 2'b00, 0, 5'd1,  32'h80FF_1234, 32'h0, 32'hFFFF_FF80, 0, 1, 3, 0));
    vecs.push_back(mk(32'h0000_2002, 2'b01, 1, 5'd7,  32'hBEEF_0000, 32'h0, 32'h0000_BEEF, 0, 1, 3, 0));
    vecs.push_back(mk(32'h0000_2002, 2'b01, 0, 5'd8,  32'hBEEF_0000, 32'h0, 32'hFFFF_BEEF, 0, 1, 3, 5));
    vecs.push_back(mk(32'h0000_4000, 2'b10, 0, 5'd9,  32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF, 0, 1, 3, 0));
    vecs.push_back(mk(32'h0000_4000, 2'b11, 1, 5'd10, 32'h1234_5678, 32'h0, 32'h1234_5678, 0, 1, 3, 0));
    vecs.push_back(mk(32'h0000_1001, 2'b00, 1, 5'd11, 32'h80FF_1234, 32'h0, 32'h0000_0012, 0, 1, 3, 0));
    vecs.push_back(mk(32'h0000_1002, 2'b00, 0, 5'd12, 32'h80FF_1234, 32'h0, 32'hFFFF_FFFF, 0, 1, 3, 0));
    vecs.push_back(mk(32'h0000_3002, 2'b01, 0, 5'd13, 32'h4433_2211, 32'h0, 32'h0000_4433, 0, 1, 3, 0));
`ifdef MISALIGNED_LOAD_EN
    vecs.push_back(mk(32'h0000_3001, 2'b10, 0, 5'd14, 32'h4433_2211, 32'h8877_6655, 32'h5544_3322, 0, 2, 5, 0));
    vecs.push_back(mk(32'h0000_3003, 2'b01, 0, 5'd15, 32'h4433_2211, 32'h8877_6655, 32'h0000_5544, 0, 2, 5, 0));
    vecs.push_back(mk(32'hFFFF_FFFE, 2'b10, 0, 5'd16, 32'hAABB_CCDD, 32'h1122_3344, 32'h3344_AABB, 0, 2, 5, 0));
    vecs.push_back(mk(32'h0000_3001, 2'b01, 0, 5'd17, 32'h4433_2211, 32'h8877_6655, 32'h0000_3322, 0, 1, 3, 0));
`else
    vecs.push_back(mk(32'h0000_3002, 2'b10, 0, 5'd14, 32'h4433_2211, 32'h0, 32'h0, 1, 0, 1, 0));
    vecs.push_back(mk(32'h0000_3001, 2'b01, 0, 5'd15, 32'h4433_2211, 32'h0, 32'h0, 1, 0, 1, 2));
    vecs.push_back(mk(32'hFFFF_FFFE, 2'b10, 0, 5'd16, 32'hAABB_CCDD, 32'h0, 32'h0, 1, 0, 1, 0));
    vecs.push_back(mk(32'h0000_3003, 2'b01, 1, 5'd17, 32'h4433_2211, 32'h0, 32'h0, 1, 0, 1, 0));
`endif
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready_o}, 32'h1);
    chk("rst_mem_valid", {31'b0, mem_req_valid_o}, 32'h0);
    chk("rst_wb_valid", {31'b0, wb_valid_o}, 32'h0);
    chk("rst_exc", {31'b0, exc_misaligned_o}, 32'h0);
    chk("rst_mem_addr", mem_addr_o, 32'h0);
    chk("rst_wb_data", wb_data_o, 32'h0);
    chk("rst_wb_rd", {27'b0, wb_rd_o}, 32'h0);
    reset_n = 1;
    foreach (vecs[i]) issue(vecs[i]);
    // Flush while waiting for the first word: its late response must be swallowed.
    rsp_delay = 2;
    mem[32'h5000] = 32'h0102_0304;
    exp_addr_q.push_back(32'h5000);
    nreq = 0;
    @(negedge clk);
    req_valid_i = 1; req_addr_i = 32'h5000; req_size_i = 2'b10; req_unsigned_i = 0; req_rd_i = 5'd3;
    @(negedge clk);
    req_valid_i = 0;
    @(negedge clk);
    flush_i = 1;
    @(negedge clk);
    flush_i = 0;
    chk("drain_ready0", {31'b0, req_ready_o}, 32'h0);
    @(negedge clk);
    chk("drain_ready1", {31'b0, req_ready_o}, 32'h0);
    @(negedge clk);
    chk("drain_done", {31'b0, req_ready_o}, 32'h1);
    for (int k = 0; k < 4; k++) begin
      chk("drain_no_wb", {31'b0, wb_valid_o}, 32'h0);
      @(negedge clk);
    end
    chk("drain_req_count", nreq, 1);
    rsp_delay = 0;
    issue(mk(32'h0000_5000, 2'b10, 0, 5'd20, 32'hCAFE_F00D, 32'h0, 32'hCAFE_F00D, 0, 1, 3, 0));
    // Flush coinciding with the request handshake drops the request.
    nreq = 0;
    @(negedge clk);
    req_valid_i = 1; req_addr_i = 32'h4000; req_size_i = 2'b10; flush_i = 1;
    @(negedge clk);
    req_valid_i = 0; flush_i = 0;
    chk("flush_hs_ready", {31'b0, req_ready_o}, 32'h1);
    chk("flush_hs_memv", {31'b0, mem_req_valid_o}, 32'h0);
    @(negedge clk);
    chk("flush_hs_nreq", nreq, 0);
    // Flush in REQ0 while memory is stalled returns straight to IDLE.
    mem_stall = 1;
    req_valid_i = 1; req_addr_i = 32'h6006; req_size_i = 2'b00;
    @(negedge clk);
    req_valid_i = 0;
    chk("req0_valid", {31'b0, mem_req_valid_o}, 32'h1);
    chk("req0_addr", mem_addr_o, 32'h6004);
    flush_i = 1;
    @(negedge clk);
    flush_i = 0;
    mem_stall = 0;
    chk("req0_flush_idle", {31'b0, req_ready_o}, 32'h1);
    chk("req0_flush_memv", {31'b0, mem_req_valid_o}, 32'h0);
    issue(mk(32'h0000_1000, 2'b00, 0, 5'd21, 32'h80FF_1234, 32'h0, 32'h0000_0034, 0, 1, 3, 0));
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
